// File: rtl/ib_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ib_mul_pkg
//  Brief    : Shared types and constants for the iceBench multiplier
//             arbiter family (FSM state encoding, operand/product widths).
//  Revision : 1.0  initial release
// ============================================================================
package ib_mul_pkg;

    // Multiplier operand and product widths
    localparam int c_OP_W = 8;
    localparam int c_PR_W = 16;

    // Arbiter sequencing states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mul_state_t;

endpackage : ib_mul_pkg
`default_nettype wire

// File: rtl/ib_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : ib_rr_pick
//  Brief    : Combinational round-robin picker. Returns the first set request
//             bit searching upward from (ptr+1) mod N, wrapping around.
//  Revision : 1.0  initial release
// ============================================================================
module ib_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // One extra bit so ptr+offset (< 2N) never overflows before the wrap
    logic [IW:0] w_sum;

    // Scan offsets from farthest to nearest so the nearest set bit wins last
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_sum   = '0;
        for (int off = N; off >= 1; off--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            if (i_req[w_sum[IW-1:0]]) begin
                o_idx   = w_sum[IW-1:0];
                o_found = 1'b1;
            end
        end
    end

endmodule : ib_rr_pick
`default_nettype wire

// File: rtl/ib_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ib_mul_arb
//  Brief    : Round-robin arbiter/sequencer sharing one start/done 8x8
//             multiplier between N requesters. Grants in IDLE, pulses start,
//             waits for done (with timeout) and returns a one-cycle ack with
//             the product to the served requester.
//  Revision : 1.0  initial release
// ============================================================================
module ib_mul_arb
    import ib_mul_pkg::*;
#(
    parameter int N   = 4,
    parameter int TMO = 64
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [N-1:0]          i_req,
    input  logic [c_OP_W*N-1:0]   i_a,
    input  logic [c_OP_W*N-1:0]   i_b,
    output logic [N-1:0]          o_ack,
    output logic [c_PR_W-1:0]     o_c,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_mul_start,
    output logic [c_OP_W-1:0]     o_mul_a,
    output logic [c_OP_W-1:0]     o_mul_b,
    input  logic [c_PR_W-1:0]     i_mul_c,
    input  logic                  i_mul_done
);

    localparam int c_IW = $clog2(N);
    localparam int c_CW = $clog2(TMO);

    mul_state_t        r_state;
    logic [c_IW-1:0]   r_ptr;
    logic [c_IW-1:0]   r_grant;
    logic [c_CW-1:0]   r_cnt;

    logic [c_IW-1:0]   w_pick_idx;
    logic              w_pick_found;
    logic [c_OP_W-1:0] w_sel_a;
    logic [c_OP_W-1:0] w_sel_b;
    logic [N-1:0]      w_grant_oh;

    ib_rr_pick #(
        .N  (N),
        .IW (c_IW)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Route the candidate requester's operands toward the multiplier latch
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < N; k++) begin
            if (w_pick_idx == c_IW'(k)) begin
                w_sel_a = i_a[k*c_OP_W +: c_OP_W];
                w_sel_b = i_b[k*c_OP_W +: c_OP_W];
            end
        end
    end

    assign w_grant_oh = N'(1) << r_grant;

    // Sequencer: grant in IDLE, one-cycle start, wait for done/timeout, one-cycle response
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= c_IW'(N-1);
            r_grant     <= '0;
            r_cnt       <= '0;
            o_ack       <= '0;
            o_c         <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_mul_start <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        o_mul_a     <= w_sel_a;
                        o_mul_b     <= w_sel_b;
                        r_grant     <= w_pick_idx;
                        o_mul_start <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    // A done level still high from the last operation is ignored here
                    o_mul_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mul_done) begin
                        o_c     <= i_mul_c;
                        o_ack   <= w_grant_oh;
                        r_ptr   <= r_grant;
                        r_state <= ST_RESP;
                    end else if (r_cnt == c_CW'(TMO-1)) begin
                        o_c     <= '0;
                        o_err   <= 1'b1;
                        o_ack   <= w_grant_oh;
                        r_ptr   <= r_grant;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // o_c deliberately keeps the last result
                    o_ack   <= '0;
                    o_err   <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ib_mul_arb
`default_nettype wire

// File: tb/tb_ib_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ib_mul_arb
//  Brief    : Self-checking bench for ib_mul_arb with a behavioural
//             start/done multiplier and an expected-response queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ib_mul_arb;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             nrst;
    logic [N-1:0]     req;
    logic [8*N-1:0]   ta;
    logic [8*N-1:0]   tbv;
    logic [N-1:0]     o_ack;
    logic [15:0]      o_c;
    logic             o_err;
    logic             o_busy;
    logic             o_mul_start;
    logic [7:0]       o_mul_a;
    logic [7:0]       o_mul_b;
    logic [15:0]      mul_c    = '0;
    logic             mul_done = 1'b0;

    int checks   = 0;
    int failures = 0;
    int ack_seen = 0;
    int acks_got = 0;
    int rem [N];

    // 0: normal latency, 1: done stuck low, 2: done stuck high
    int mul_mode = 0;
    int mul_lat  = 3;
    int mul_cnt  = 0;

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] c;
        logic        err;
    } exp_t;
    exp_t sbq [$];

    always #5 clk = ~clk;

    ib_mul_arb #(.N(N), .TMO(TMO)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_req       (req),
        .i_a         (ta),
        .i_b         (tbv),
        .o_ack       (o_ack),
        .o_c         (o_c),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_mul_start (o_mul_start),
        .o_mul_a     (o_mul_a),
        .o_mul_b     (o_mul_b),
        .i_mul_c     (mul_c),
        .i_mul_done  (mul_done)
    );

    // Behavioural multiplier: done rises mul_lat edges after start and stays high until next start
    always @(posedge clk) begin
        case (mul_mode)
            1: mul_done <= 1'b0;
            2: begin
                mul_done <= 1'b1;
                mul_c    <= {8'h00, o_mul_a} * {8'h00, o_mul_b};
            end
            default: begin
                if (o_mul_start) begin
                    mul_cnt  <= 1;
                    mul_done <= 1'b0;
                end else if (mul_cnt != 0) begin
                    if (mul_cnt >= mul_lat) begin
                        mul_done <= 1'b1;
                        mul_c    <= {8'h00, o_mul_a} * {8'h00, o_mul_b};
                        mul_cnt  <= 0;
                    end else begin
                        mul_cnt <= mul_cnt + 1;
                    end
                end
            end
        endcase
    end

    // Count every cycle in which an ack is presented
    always @(posedge clk) begin
        if (|o_ack) ack_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic push);
        ta[8*k +: 8]  = a;
        tbv[8*k +: 8] = b;
        req[k]        = 1'b1;
        rem[k]        = rem[k] + 1;
        if (push) sbq.push_back('{idx: 8'(k), c: {8'h00, a} * {8'h00, b}, err: 1'b0});
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!o_mul_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", {31'h0, o_mul_start}, 1);
    endtask

    task automatic wait_ack(input int budget, output int waited);
        int   n;
        logic got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (|o_ack) got = 1'b1;
        end
        waited = n;
        if (!got) begin
            chk("ack_timeout", 0, 1);
            return;
        end
        acks_got++;
        if (sbq.size() == 0) begin
            chk("unexpected_ack", {28'h0, o_ack}, 0);
        end else begin
            e = sbq.pop_front();
            chk("ack_onehot", {28'h0, o_ack}, 32'(1) << e.idx);
            chk("o_c", {16'h0, o_c}, {16'h0, e.c});
            chk("o_err", {31'h0, o_err}, {31'h0, e.err});
            if (rem[e.idx] > 0) rem[e.idx] = rem[e.idx] - 1;
            if (rem[e.idx] == 0) req[e.idx] = 1'b0;
        end
        @(negedge clk);
        chk("ack_one_cycle", {28'h0, o_ack}, 0);
        chk("err_one_cycle", {31'h0, o_err}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   {28'h0, o_ack}, 0);
        chk({tag, "_c"},     {16'h0, o_c}, 0);
        chk({tag, "_err"},   {31'h0, o_err}, 0);
        chk({tag, "_busy"},  {31'h0, o_busy}, 0);
        chk({tag, "_start"}, {31'h0, o_mul_start}, 0);
        chk({tag, "_mul_a"}, {24'h0, o_mul_a}, 0);
        chk({tag, "_mul_b"}, {24'h0, o_mul_b}, 0);
    endtask

    initial begin
        int w;
        logic [7:0] a;
        logic [7:0] b;
        nrst = 1'b0;
        req  = '0;
        ta   = '0;
        tbv  = '0;
        for (int k = 0; k < N; k++) rem[k] = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Single request on requester 2, done 3 edges after start
        issue(2, 8'h0F, 8'h11, 1'b1);
        wait_start(10);
        chk("t1_mul_a", {24'h0, o_mul_a}, 32'h0F);
        chk("t1_mul_b", {24'h0, o_mul_b}, 32'h11);
        chk("t1_busy", {31'h0, o_busy}, 1);
        @(negedge clk);
        chk("t1_start_one_cycle", {31'h0, o_mul_start}, 0);
        wait_ack(20, w);
        chk("t1_c_held", {16'h0, o_c}, 32'h00FF);
        chk("t1_busy_idle", {31'h0, o_busy}, 0);

        // Fresh pointer (N-1) so a full sweep starts at requester 0
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        // All four requesting continuously: order 0,1,2,3,0
        for (int k = 0; k < N; k++) issue(k, 8'(k + 1), 8'hFF, 1'b1);
        rem[0] = rem[0] + 1;
        sbq.push_back('{idx: 8'd0, c: 16'h00FF, err: 1'b0});
        for (int i = 0; i < 5; i++) wait_ack(40, w);

        // Directed sweep on requester 1 with corner operands
        mul_lat = 4;
        for (int i = 0; i < 200; i++) begin
            a = 8'(i * 7 + 3);
            b = 8'(i * 13 + 5);
            if (i == 0) begin a = 8'hFF; b = 8'hFF; end
            if (i == 1) begin a = 8'h00; b = 8'hFF; end
            if (i == 2) begin a = 8'hFF; b = 8'h01; end
            issue(1, a, b, 1'b1);
            wait_ack(30, w);
        end

        // Timeout: done never arrives
        mul_mode = 1;
        issue(0, 8'h12, 8'h34, 1'b0);
        sbq.push_back('{idx: 8'd0, c: 16'h0000, err: 1'b1});
        wait_start(10);
        wait_ack(TMO + 10, w);
        chk("timeout_latency", w, TMO + 1);
        mul_mode = 0;
        mul_lat  = 3;
        issue(1, 8'h12, 8'h34, 1'b1);
        wait_ack(30, w);

        // Stale done held high: captured on the first WAIT edge
        mul_mode = 2;
        issue(2, 8'h55, 8'h03, 1'b1);
        wait_start(10);
        wait_ack(10, w);
        chk("stale_latency", w, 2);
        issue(3, 8'h0A, 8'h0B, 1'b1);
        wait_ack(20, w);
        repeat (4) @(negedge clk);
        chk("stale_ack_count", ack_seen, acks_got);
        mul_mode = 0;

        // Reset during WAIT abandons the transaction
        issue(1, 8'h09, 8'h09, 1'b0);
        wait_start(10);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk_all_zero("midreset");
        req[1] = 1'b0;
        rem[1] = 0;
        issue(3, 8'h80, 8'h80, 1'b1);
        @(negedge clk);
        nrst = 1'b1;
        wait_ack(20, w);
        repeat (4) @(negedge clk);
        chk("total_ack_count", ack_seen, acks_got);
        chk("queue_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ib_mul_arb
`default_nettype wire

// File: doc/ib_mul_arb.md
Name: ib_mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8x8 start/done multiplier (ib_mul_8x8 family) between N requesters.
- Accepts per-requester operand requests and drives the multiplier's start pulse and operands.
- Waits for done, then returns the 16-bit product with a one-cycle acknowledge to the granted requester.
- Sits between client blocks and a single multiplier instance in the iceBench datapath.

Parameters:
- N, 4, number of requesters (2..8).
- TMO, 64, maximum cycles spent in WAIT before the timeout error fires (>=4).

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_req  in  N  per-requester request level. Held high with operands stable until that requester's o_ack bit pulses.
- i_a  in  8*N  operand A. Requester k drives bits [8k+7:8k].
- i_b  in  8*N  operand B. Same packing as i_a.
- o_ack  out  N  one-hot, one-cycle acknowledge to the served requester.
- o_c  out  16  product. Valid while o_ack != 0.
- o_err  out  1  high with o_ack when the multiplier timed out. o_c=0 in that case.
- o_busy  out  1  high whenever state != IDLE.
- o_mul_start  out  1  start pulse to the multiplier.
- o_mul_a  out  8  operand A to the multiplier.
- o_mul_b  out  8  operand B to the multiplier.
- i_mul_c  in  16  multiplier product.
- i_mul_done  in  1  multiplier done.

Behaviour:
- Reset (async, i_nrst=0): state=IDLE, rr pointer=N-1. All outputs 0: o_ack, o_c, o_err, o_busy, o_mul_start, o_mul_a, o_mul_b. Reset mid-operation abandons the transaction; no ack is ever issued for it.
- FSM states: IDLE, START, WAIT, RESP. All outputs are registered.
- IDLE: i_req is sampled only in this state.
  - If any i_req bit is set, grant the first set bit searching from (ptr+1) mod N upward, wrapping.
  - On that edge: latch the granted requester's operands into o_mul_a/o_mul_b, store the grant index, set o_mul_start=1, go to START.
  - If no request: stay in IDLE; outputs unchanged.
- START: o_mul_start is high for exactly this one cycle. Next edge: o_mul_start=0, clear the timeout counter, go to WAIT.
- WAIT:
  - i_mul_done is honoured only in WAIT, so a stale done level from the previous operation seen during START is ignored.
  - If i_mul_done=1 at an edge: o_c<=i_mul_c, o_ack<=onehot(grant), ptr<=grant, go to RESP.
  - Else, if the counter equals TMO-1: o_c<=0, o_err<=1, o_ack<=onehot(grant), ptr<=grant, go to RESP.
  - Otherwise increment the counter.
- RESP: o_ack/o_c/o_err are valid for exactly this one cycle. Next edge: clear o_ack and o_err, go to IDLE.
  - o_c holds its last value after RESP.
  - A requester that drops i_req on the edge ending RESP is not re-served.
- Operand stability: o_mul_a/o_mul_b stay constant from START until the next grant.
- Changes to i_a, i_b or i_req of any requester after the grant do not affect the transaction in flight.
- Throughput: minimum 4 cycles per operation plus the multiplier latency. Back-to-back requests from different requesters have one idle cycle between RESP and the next START.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,...,N-1,0,... A requester waits at most N-1 other transactions.
- Widths: o_c is exactly i_mul_c. No arithmetic is performed in this block. Index width is clog2(N).

Decomposition:
- Shared package ib_mul_pkg:
  - FSM state encoding (IDLE/START/WAIT/RESP, 2 bits).
  - Operand width 8 and product width 16 constants.
- One sub-module ib_rr_pick (combinational): inputs are the request vector and pointer; outputs are the grant index and a found flag. It is reusable by other arbiters.

Test Plan:
- Single request: req[2]=1, a=0x0F, b=0x11, multiplier done 3 cycles after start. Required: o_mul_start high one cycle with o_mul_a=0x0F, o_mul_b=0x11; o_ack=4'b0100 one cycle with o_c=0x00FF, o_err=0.
- All four requesting continuously with a[k]=k+1, b[k]=0xFF. Required: grant order 0,1,2,3,0; products 0x00FF, 0x01FE, 0x02FD, 0x03FC; each ack exactly one cycle.
- Exhaustive sweep through a real ib_mul_8x8_s0_l4 on requester 1: all 65536 a,b pairs. Required: every o_c == a*b, o_err never set.
- Timeout: tie i_mul_done=0 with a request on req[0]. Required: ack on req[0] with o_err=1, o_c=0, exactly TMO cycles after WAIT entry. Next request is still served normally afterwards.
- Stale done: i_mul_done held high continuously. Required: it is not sampled in START; result is captured on the first WAIT edge; exactly one ack per request.
- Reset mid-operation: assert i_nrst=0 during WAIT. Required: all outputs 0 immediately; no ack; after release, a pending req[3] with a=0x80, b=0x80 is granted with o_c=0x4000.
